// File: rtl/hwalu_core.sv
// hwalu_core: registered multi-mode signed multiply/accumulate ALU.
// Modes (opcode[3:2]): 00 muladd, 01 dot-product accumulate, 10 complex
// multiply, 11 hold. opcode[1:0] carries no meaning.
module hwalu_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl,
   input  logic [31:0] operanda,
   input  logic [31:0] operandb,
   input  logic        accmu,
   input  logic [3:0]  opcode,
   output logic [63:0] result
);

   typedef enum logic [1:0] {
      MODE_MULADD = 2'b00,
      MODE_DOTSUM = 2'b01,
      MODE_CPLX   = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   mode_e       mode;
   logic [63:0] result_q, result_d;

   // All arithmetic is done on explicitly sign-extended operands in plain
   // vectors; the low bits of an unsigned product of sign-extended values
   // are the two's complement product.
   logic [63:0] a_ext, b_ext, p_mul, p_mul_n;
   logic [15:0] lane_prod [4];
   logic [17:0] dot_sum;
   logic [63:0] p_dot, p_dot_n;
   logic [31:0] ar_ext, ai_ext, br_ext, bi_ext;
   logic [31:0] rr, ii, ri, ir;
   logic [32:0] re_wide, im_wide;
   logic [31:0] re, im, re_n, im_n;
   logic [63:0] p_cplx;
   logic        unused_bits;

   assign mode = mode_e'(opcode[3:2]);

   assign a_ext   = {{32{operanda[31]}}, operanda};
   assign b_ext   = {{32{operandb[31]}}, operandb};
   assign p_mul   = a_ext * b_ext;
   assign p_mul_n = ctrl ? (64'd0 - p_mul) : p_mul;

   // Four signed 8x8 lane products summed at 18 bits so the extreme case
   // (4 x 16384) cannot overflow before sign extension.
   always_comb begin
      dot_sum = '0;
      for (int i = 0; i < 4; i++) begin
         lane_prod[i] = {{8{operanda[8*i+7]}}, operanda[8*i +: 8]} *
                        {{8{operandb[8*i+7]}}, operandb[8*i +: 8]};
         dot_sum      = dot_sum + {{2{lane_prod[i][15]}}, lane_prod[i]};
      end
   end

   assign p_dot   = {{46{dot_sum[17]}}, dot_sum};
   assign p_dot_n = ctrl ? (64'd0 - p_dot) : p_dot;

   assign ar_ext = {{16{operanda[15]}}, operanda[15:0]};
   assign ai_ext = {{16{operanda[31]}}, operanda[31:16]};
   assign br_ext = {{16{operandb[15]}}, operandb[15:0]};
   assign bi_ext = {{16{operandb[31]}}, operandb[31:16]};

   assign rr = ar_ext * br_ext;
   assign ii = ai_ext * bi_ext;
   assign ri = ar_ext * bi_ext;
   assign ir = ai_ext * br_ext;

   // Real and imaginary parts are formed at 33 bits, then cut to 32; the
   // negated halves wrap independently, so -2^31 maps to itself.
   assign re_wide = {rr[31], rr} - {ii[31], ii};
   assign im_wide = {ri[31], ri} + {ir[31], ir};
   assign re      = re_wide[31:0];
   assign im      = im_wide[31:0];
   assign re_n    = ctrl ? (32'd0 - re) : re;
   assign im_n    = ctrl ? (32'd0 - im) : im;
   assign p_cplx  = {im_n, re_n};

   assign unused_bits = re_wide[32] ^ im_wide[32] ^ (^opcode[1:0]);

   // Next-value select: accumulate, load, or hold depending on mode.
   always_comb begin
      result_d = result_q;
      unique case (mode)
         MODE_MULADD: result_d = accmu ? (result_q + p_mul_n) : p_mul_n;
         MODE_DOTSUM: result_d = result_q + p_dot_n;
         MODE_CPLX:   result_d = p_cplx;
         MODE_HOLD:   result_d = result_q;
         default:     result_d = result_q;
      endcase
   end

   // Result register with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_hwalu_core.sv
// Scoreboard bench for hwalu_core: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares against result.
module tb_hwalu_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        ctrl;
   logic [31:0] operanda;
   logic [31:0] operandb;
   logic        accmu;
   logic [3:0]  opcode;
   logic [63:0] result;

   typedef struct {
      string       name;
      logic [63:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   hwalu_core dut (
      .clk      (clk),
      .rst      (rst),
      .ctrl     (ctrl),
      .operanda (operanda),
      .operandb (operandb),
      .accmu    (accmu),
      .opcode   (opcode),
      .result   (result)
   );

   always #5 clk = ~clk;

   // Monitor: result is valid every cycle; compare whenever an expectation is pending.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_checks++;
         if (result !== e.exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", e.name, result, e.exp);
         end
      end
   end

   task automatic step(input logic r, input logic [3:0] op, input logic acc,
                       input logic c, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string name);
      exp_t e;
      rst      = r;
      opcode   = op;
      accmu    = acc;
      ctrl     = c;
      operanda = a;
      operandb = b;
      @(posedge clk);
      #1;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   localparam logic [63:0] CPLX_P = 64'h0102_6000_FFFC_C000;
   localparam logic [63:0] CPLX_N = 64'hFEFD_A000_0003_4000;
   localparam logic [63:0] NEG_SQ = 64'hFFFF_FFFF_FFFC_03FF;

   initial begin
      rst = 1'b1; opcode = '0; accmu = 1'b0; ctrl = 1'b0;
      operanda = '0; operandb = '0;

      step(1, 4'b0000, 0, 0, 32'h0, 32'h0, 64'h0, "reset0");
      step(1, 4'b0100, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 64'h0, "reset1");

      // muladd accumulate
      step(0, 4'b0000, 1, 0, 32'h0000_01FF, 32'h0000_01FF, 64'h0000_0000_0003_FC01, "mac1");
      step(0, 4'b0000, 1, 0, 32'h0030_0001, 32'h0020_0001, 64'h0000_0600_0053_FC02, "mac2");
      step(0, 4'b0000, 1, 0, 32'h8020_0001, 32'h8010_0001, 64'h3FE8_07FF_0083_FC03, "mac3");
      // muladd load and negate
      step(0, 4'b0000, 0, 0, 32'h0000_01FF, 32'h0000_01FF, 64'h0000_0000_0003_FC01, "load");
      step(0, 4'b0000, 0, 1, 32'h0000_01FF, 32'h0000_01FF, NEG_SQ, "load_neg");
      // reserved mode holds regardless of operands
      step(0, 4'b1100, 1, 1, $urandom(), $urandom(), NEG_SQ, "hold1");
      step(0, 4'b1110, 0, 0, $urandom(), $urandom(), NEG_SQ, "hold2");
      // muladd extremes
      step(0, 4'b0000, 0, 0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mul_min");
      step(0, 4'b0000, 0, 1, 32'h8000_0000, 32'h8000_0000, 64'hC000_0000_0000_0000, "mul_min_neg");
      step(1, 4'b0000, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, "reset_mac");

      // dotsum
      step(0, 4'b0100, 0, 0, 32'h1203_0421, 32'h4211_56F1, 64'h440, "dot1");
      step(0, 4'b0100, 1, 0, 32'h1203_0421, 32'h4211_56F1, 64'h880, "dot2");
      step(0, 4'b0111, 0, 0, 32'h1203_0421, 32'h4211_56F1, 64'hCC0, "dot3_op11");
      step(0, 4'b0101, 0, 1, 32'h1203_0421, 32'h4211_56F1, 64'h880, "dot_neg");
      step(1, 4'b0100, 1, 0, 32'h1203_0421, 32'h4211_56F1, 64'h0, "reset_dot");
      step(0, 4'b0100, 0, 0, 32'h8080_8080, 32'h8080_8080, 64'h1_0000, "dot_min");
      step(0, 4'b0110, 0, 1, 32'h8080_8080, 32'h8080_8080, 64'h0, "dot_min_neg");

      // complex
      step(1, 4'b1000, 0, 0, 32'h0, 32'h0, 64'h0, "reset_cplx");
      step(0, 4'b1000, 0, 0, 32'h0200_F000, 32'hF020_0230, CPLX_P, "cplx1");
      step(0, 4'b1000, 1, 0, 32'h0200_F000, 32'hF020_0230, CPLX_P, "cplx_held");
      step(0, 4'b1011, 1, 1, 32'h0200_F000, 32'hF020_0230, CPLX_N, "cplx_neg");
      // mode switch accumulates onto current value
      step(0, 4'b0100, 0, 0, 32'h1203_0421, 32'h4211_56F1, 64'hFEFD_A000_0003_4440, "switch_dot");
      step(0, 4'b1111, 1, 0, $urandom(), $urandom(), 64'hFEFD_A000_0003_4440, "hold3");
      step(1, 4'b1000, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 64'h0, "reset_any");
      // complex wrap of im = 2^31, negation keeps -2^31
      step(0, 4'b1000, 0, 0, 32'h8000_8000, 32'h8000_8000, 64'h8000_0000_0000_0000, "cplx_wrap");
      step(0, 4'b1010, 0, 1, 32'h8000_8000, 32'h8000_8000, 64'h8000_0000_0000_0000, "cplx_wrap_neg");
      step(0, 4'b1001, 0, 0, 32'h0200_F000, 32'hF020_0230, CPLX_P, "cplx_op01");

      // muladd with opcode[1:0] nonzero
      step(1, 4'b0000, 0, 0, 32'h0, 32'h0, 64'h0, "reset_mac2");
      step(0, 4'b0010, 1, 0, 32'h0000_01FF, 32'h0000_01FF, 64'h0000_0000_0003_FC01, "mac1_op10");
      step(0, 4'b0001, 1, 0, 32'h0030_0001, 32'h0020_0001, 64'h0000_0600_0053_FC02, "mac2_op01");
      step(0, 4'b0011, 1, 0, 32'h8020_0001, 32'h8010_0001, 64'h3FE8_07FF_0083_FC03, "mac3_op11");
      step(0, 4'b0011, 0, 1, 32'h0000_01FF, 32'h0000_01FF, NEG_SQ, "load_neg_op11");

      repeat (3) @(posedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hwalu_core.md
Name: hwalu_core

Overview:
- Registered multi-mode signed multiply/accumulate ALU producing a 64-bit result.
- Three modes, selected by opcode[3:2]:
  - 32x32 multiply-accumulate.
  - 4-lane 8-bit dot-product accumulate.
  - 16-bit complex multiply, with optional negation.
- Used as the arithmetic datapath of a DSP-style execution unit.
- Single clock domain; one new operation accepted every cycle.

Parameters:
- None. All widths are fixed: operands 32 bits, result 64 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ctrl  input  1  negate control: 1 = negate the mode's product before it is used.
- operanda  input  32  operand A.
- operandb  input  32  operand B.
- accmu  input  1  accumulate enable, muladd mode only.
- opcode  input  4  [3:2] selects mode; [1:0] reserved, ignored.
- result  output  64  registered accumulator/result.

Behaviour:
- Reset: when rst=1 at a rising edge, the result register becomes 0. Reset has priority over every other input and may occur mid-accumulation.
- Latency: operands sampled at edge N are reflected in result immediately after edge N. There is no handshake; every non-reset cycle performs one operation.
- All arithmetic is two's complement. The 64-bit register wraps modulo 2^64 and no saturation is applied.
- Term P, per mode:
  - muladd: P = sext64(A) * sext64(B), full signed 64-bit product.
  - dotsum: P = sum over i of sext(A byte i) * sext(B byte i), for the four signed 8-bit lanes. Each lane product is 16 bits signed; the sum is sign-extended to 64 bits.
  - complex: P is built from halves.
    - ar = A[15:0] and ai = A[31:16], both signed 16-bit. br and bi are taken the same way from B.
    - re = ar*br − ai*bi.
    - im = ar*bi + ai*br.
    - Each of re and im is computed at least 33 bits wide, then truncated to 32 bits.
    - P = {im, re}.
- ctrl=1 negation:
  - muladd and dotsum: P := −P in 64 bits.
  - complex: re := −re and im := −im, each a 32-bit wrap, so −2^31 stays −2^31.
- opcode[3:2] = 00 (muladd): if accmu=1, result <= result + P; if accmu=0, result <= P.
- opcode[3:2] = 01 (dotsum): result <= result + P every cycle; accmu is ignored. Use rst to clear before a new dot sequence.
- opcode[3:2] = 10 (complex): result <= P with no accumulation; accmu is ignored.
- opcode[3:2] = 11: result holds its value (no-op).
- Mode switch: no flush. A switch into an accumulating mode accumulates onto the current result register.
- Implementation: all products are combinational and feed one 64-bit register. The multipliers may be shared across modes.

Test Plan:
- muladd accumulate:
  - Stimulus: reset, then opcode=0000, accmu=1, ctrl=0, and these operand pairs, each held exactly one cycle:
    - A=0x000001FF, B=0x000001FF.
    - A=0x00300001, B=0x00200001.
    - A=0x80200001, B=0x80100001.
  - Required result after each cycle: 0x3FC01, then 0x0600_0053_FC02, then 0x3FE8_07FF_0083_FC03 (checks the signed product).
- muladd load and negate:
  - Stimulus: accmu=0, A=0x000001FF, B=0x000001FF, ctrl=0, then the same operands with ctrl=1.
  - Required result: 0x3FC01, then 0xFFFF_FFFF_FFFC_03FF.
- dotsum:
  - Stimulus: reset, then opcode=0100, A=0x12030421, B=0x421156F1.
  - Required result: 0x440 after 1 cycle, 0x880 after 2 cycles. Lane 0x21*0xF1 must count as −495.
- complex:
  - Stimulus: reset, then opcode=1000, A=0x0200F000, B=0xF0200230, ctrl=0.
  - Required result: 0x0102_6000_FFFC_C000, unchanged over 2 held cycles.
  - Then ctrl=1 with the same operands: required result 0xFEFD_A000_0003_4000.
- reset mid-accumulation: after any accumulating sequence, assert rst for one cycle; result must be 0 on the next edge regardless of opcode, accmu or operands.
- reserved opcode: opcode=1100 with arbitrary operands must hold the prior result; opcode[1:0] values 01/10/11 must give the same results as 00 in all modes.
